if_pc_unit: RTL and testbench

- Instruction-fetch control stage of the pipeline. Holds the program counter, drives the instruction-memory address, and computes the sequential PC (PC + PC_STEP).
- Selects the next PC from sequential, branch or jump sources.
- Owns the IF/ID pipeline register: captures the fetched instruction and its PC+PC_STEP for the decode stage, with stall and flush control.

---
 rtl/if_pc_unit_pkg.sv | 11 +
 rtl/if_pc_unit_if_id_reg.sv | 37 +++
 rtl/if_pc_unit.sv | 63 ++++++
 tb/tb_if_pc_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/if_pc_unit_pkg.sv
// Shared fetch-stage constants: bus widths, reset vector and NOP encoding.
// Imported by the PC unit and the IF/ID register.
package if_pc_unit_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC_STEP_B = 4;
  localparam logic [ADDR_W-1:0]  RESET_VEC = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/if_pc_unit_if_id_reg.sv
// IF/ID pipeline register with hold enable and synchronous clear to NOP.
// Latency: one edge. Clear beats enable; enable low holds all outputs.
// Backpressure: en low (hazard stall) freezes the contents.
module if_id_reg
  import if_pc_unit_pkg::*;
#(
  parameter int unsigned B = ADDR_W,
  parameter int unsigned W = INSTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] instr_d,
  input  logic [B-1:0] pc_plus4_d,
  output logic [W-1:0] instr,
  output logic [B-1:0] pc_plus4,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= W'(NOP_INSTR);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (clr) begin
      instr    <= W'(NOP_INSTR);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= instr_d;
      pc_plus4 <= pc_plus4_d;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_pc_unit.sv
// Instruction-fetch control: PC register, next-PC select and the IF/ID register.
// Latency: instruction at imem_addr A reaches if_id_instr one edge later.
// Backpressure: stall freezes PC and IF/ID; a jump/branch redirect overrides stall.
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter int unsigned   B        = ADDR_W,
  parameter int unsigned   W        = INSTR_W,
  parameter logic [B-1:0]  RESET_PC = B'(RESET_VEC),
  parameter int unsigned   PC_STEP  = PC_STEP_B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [B-1:0] branch_target,
  input  logic         jump,
  input  logic [B-1:0] jump_target,
  output logic [B-1:0] imem_addr,
  input  logic [W-1:0] imem_data,
  output logic [W-1:0] if_id_instr,
  output logic [B-1:0] if_id_pc_plus4,
  output logic         if_id_valid
);

  logic [B-1:0] pc;
  logic [B-1:0] pc_seq;
  logic         redirect;

  // Carry out of the top bit is dropped, so the PC wraps to zero.
  assign pc_seq    = pc + B'(PC_STEP);
  assign redirect  = jump | branch_taken;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (jump) begin
      pc <= jump_target;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (!stall) begin
      pc <= pc_seq;
    end
  end

  if_id_reg #(
    .B (B),
    .W (W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (~stall),
    .clr        (flush | redirect),
    .instr_d    (imem_data),
    .pc_plus4_d (pc_seq),
    .instr      (if_id_instr),
    .pc_plus4   (if_id_pc_plus4),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed bench for if_pc_unit: default instance plus a wrap-around instance.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_data, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;

  logic        rst_n_w;
  logic        z_stall, z_flush, z_br, z_jmp;
  logic [31:0] z_btgt, z_jtgt;
  logic [31:0] imem_addr_w, imem_data_w, if_id_instr_w, if_id_pc_plus4_w;
  logic        if_id_valid_w;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    bit          sel;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Instruction memory model: word content is a tag plus its address.
  assign imem_data   = 32'h1000_0000 + imem_addr;
  assign imem_data_w = 32'h1000_0000 + imem_addr_w;

  if_pc_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid)
  );

  if_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .stall(z_stall), .flush(z_flush),
    .branch_taken(z_br), .branch_target(z_btgt),
    .jump(z_jmp), .jump_target(z_jtgt),
    .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .if_id_instr(if_id_instr_w), .if_id_pc_plus4(if_id_pc_plus4_w),
    .if_id_valid(if_id_valid_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit sel, input logic [31:0] addr,
                      input logic [31:0] instr, input logic [31:0] pc4, input logic vld);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = addr; e.instr = instr; e.pc4 = pc4; e.vld = vld;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      chk({e.tag, ".addr"},  imem_addr_w,      e.addr);
      chk({e.tag, ".instr"}, if_id_instr_w,    e.instr);
      chk({e.tag, ".pc4"},   if_id_pc_plus4_w, e.pc4);
      chk({e.tag, ".valid"}, {31'd0, if_id_valid_w}, {31'd0, e.vld});
    end else begin
      chk({e.tag, ".addr"},  imem_addr,        e.addr);
      chk({e.tag, ".instr"}, if_id_instr,      e.instr);
      chk({e.tag, ".pc4"},   if_id_pc_plus4,   e.pc4);
      chk({e.tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.vld});
    end
  endtask

  // Check current state without an edge.
  task automatic now(input string tag, input bit sel, input logic [31:0] addr,
                     input logic [31:0] instr, input logic [31:0] pc4, input logic vld);
    push(tag, sel, addr, instr, pc4, vld);
    #1;
    pop_compare();
  endtask

  // Expect this state one edge from now; samples 1 time unit after the edge.
  task automatic step(input string tag, input bit sel, input logic [31:0] addr,
                      input logic [31:0] instr, input logic [31:0] pc4, input logic vld);
    push(tag, sel, addr, instr, pc4, vld);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    z_stall = 1'b0; z_flush = 1'b0; z_br = 1'b0; z_jmp = 1'b0;
    z_btgt = '0; z_jtgt = '0;

    #11;
    now("reset", 0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    now("first_fetch", 0, 32'h0, 32'h0, 32'h0, 1'b0);

    step("run1", 0, 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    step("run2", 0, 32'h8, 32'h1000_0004, 32'h8, 1'b1);

    stall = 1'b1;
    step("stall1", 0, 32'h8, 32'h1000_0004, 32'h8, 1'b1);
    step("stall2", 0, 32'h8, 32'h1000_0004, 32'h8, 1'b1);
    stall = 1'b0;
    step("resume1", 0, 32'hC,  32'h1000_0008, 32'hC,  1'b1);
    step("resume2", 0, 32'h10, 32'h1000_000C, 32'h10, 1'b1);

    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    step("branch_over_stall", 0, 32'h40, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0; stall = 1'b0;
    step("branch_target_fetch", 0, 32'h44, 32'h1000_0040, 32'h44, 1'b1);

    jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h80;
    step("jump_over_branch", 0, 32'h100, 32'h0, 32'h0, 1'b0);
    jump = 1'b0; branch_taken = 1'b0;
    step("jump_target_fetch", 0, 32'h104, 32'h1000_0100, 32'h104, 1'b1);

    jump = 1'b1; jump_target = 32'h1C;
    step("jump_1c", 0, 32'h1C, 32'h0, 32'h0, 1'b0);
    jump = 1'b0;
    step("fetch_1c", 0, 32'h20, 32'h1000_001C, 32'h20, 1'b1);

    flush = 1'b1; stall = 1'b1;
    step("flush_stall", 0, 32'h20, 32'h0, 32'h0, 1'b0);
    flush = 1'b0; stall = 1'b0;
    step("after_flush", 0, 32'h24, 32'h1000_0020, 32'h24, 1'b1);

    #3;
    rst_n = 1'b0;
    now("async_reset", 0, 32'h0, 32'h0, 32'h0, 1'b0);

    @(posedge clk); #1;
    rst_n_w = 1'b1;
    now("wrap_reset", 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    step("wrap_edge", 1, 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1);
    step("wrap_next", 1, 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    #3;
    rst_n_w = 1'b0;
    now("wrap_async_reset", 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
